// File: rtl/dcache_direct_wb_if.sv
// dcache_direct_wb_if
//   Bundles the processor-side (MEM stage) request/response signals and the
//   memory-side line transfer signals of the direct-mapped data cache.
//   Ports (by group):
//     processor : proc_read, proc_write, proc_addr[29:0], proc_wdata[31:0]
//                 -> cache; proc_rdata[31:0], proc_stall <- cache
//     memory    : mem_read, mem_write, mem_addr[27:0], mem_wdata[127:0]
//                 <- cache; mem_rdata[127:0], mem_ready -> cache
//   Modports: slave = cache side, master = processor/memory environment.
interface dcache_direct_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb
//   Direct-mapped, write-back, write-allocate data cache between the MEM
//   stage and slow data memory. 32-bit word accesses, 128-bit line transfers,
//   pipeline stalled while a miss is being serviced.
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : dcache_direct_wb_if.slave (processor request/response and
//             memory line read/write handshake)
//   Parameter NUM_LINES: number of lines, power of two in 2..64.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | serve hits; on a miss choose write-back or direct fill
//   WRITEBACK | dirty victim line being written to memory
//   ALLOCATE  | requested line being fetched from memory
module dcache_direct_wb #(
  parameter int NUM_LINES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dcache_direct_wb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       word_sel;
  logic             req;
  logic             hit;

  logic [3:0][31:0] line_words;
  logic [3:0][31:0] merged_line;

  logic         stall;
  logic [31:0]  rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         wr_hit;
  logic         fill;
  logic         wb_done;

  assign idx      = bus.proc_addr[IDX_W+1:2];
  assign req_tag  = bus.proc_addr[29:IDX_W+2];
  assign word_sel = bus.proc_addr[1:0];
  assign req      = bus.proc_read | bus.proc_write;
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

  assign line_words = data_q[idx];

  always_comb begin
    merged_line           = line_words;
    merged_line[word_sel] = bus.proc_wdata;
  end

  // Memory outputs are decoded from the state and the (held) request address,
  // so they stay constant for the whole transfer.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rdata     = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 28'h0;
    mem_wdata = 128'h0;
    wr_hit    = 1'b0;
    fill      = 1'b0;
    wb_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // write wins when read and write are both requested
            if (bus.proc_write) wr_hit = 1'b1;
            else                rdata  = line_words[word_sel];
          end else begin
            stall = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
            else                              state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = data_q[idx];
        if (bus.mem_ready) begin
          wb_done = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = {req_tag, idx};
        if (bus.mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q gates their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= bus.mem_rdata;
    end else if (wr_hit) begin
      data_q[idx] <= merged_line;
    end
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
Direct-mapped, write-back, write-allocate data cache. It sits between the pipeline's MEM stage (DCACHE_* port) and the slow data memory (mem_*_D).
- Serves 32-bit word accesses from the processor.
- Stalls the pipeline on a miss.
- Exchanges 128-bit lines with memory.

Parameters:
NUM_LINES, 8, number of cache lines; power of two, 2..64. IDX_W = log2(NUM_LINES). TAG_W = 28 - IDX_W.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
proc_read  input  1  processor load request, held until proc_stall is low
proc_write  input  1  processor store request, held until proc_stall is low
proc_addr  input  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag
proc_wdata  input  32  store data
proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0
proc_stall  output  1  high while the request cannot complete this cycle
mem_read  output  1  line fill request, level, held until mem_ready
mem_write  output  1  line write-back request, level, held until mem_ready
mem_addr  output  28  line address (byte address bits 31:4) = {tag, index}
mem_wdata  output  128  victim line; word k on bits [32k+31:32k]
mem_rdata  input  128  fill line, same word packing
mem_ready  input  1  one-cycle pulse: access complete; mem_rdata valid in the same cycle for reads

Behaviour:
- Storage per line: valid bit, dirty bit, TAG_W-bit tag, 128-bit data.
- Reset (asynchronous):
  - All valid and dirty bits cleared; state = IDLE.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - proc_stall = 0 when no request is present; proc_rdata = 0.
  - Tag and data arrays are not required to reset.
  - Reset mid-WRITEBACK or mid-ALLOCATE abandons the transfer. Dirty data is lost by design.
- Request: req = proc_read | proc_write. If both are high, treat as a write.
- hit = valid[idx] & (tag[idx] == addr tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - proc_stall = req & ~hit, combinational.
  - Read hit: proc_rdata = selected word, same cycle, zero added latency.
  - Write hit: the selected word is written at the clock edge; dirty set. Other words are unchanged.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
  - No request: stay in IDLE; proc_stall = 0; no memory activity.
- WRITEBACK:
  - mem_write = 1, mem_addr = {victim tag, idx}, mem_wdata = victim line; proc_stall = 1.
  - On mem_ready: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - mem_read = 1, mem_addr = {request tag, idx}; proc_stall = 1.
  - On mem_ready: line data = mem_rdata, tag = request tag, valid = 1, dirty = 0; go to IDLE.
  - The next cycle is a hit. A pending write is then merged and sets dirty.
- Memory outputs are registered or state-decoded, and are stable for the whole transaction.
- mem_read and mem_write are never high together.
- At most one outstanding memory transaction.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- proc_addr, proc_wdata, proc_read and proc_write are stable while proc_stall = 1. The cache latches nothing from them mid-miss except via the live inputs.
- Miss latency, cold line: 1 (IDLE) + fill cycles + 1 (hit cycle).
- Miss latency, dirty line: additionally the write-back cycles.

Test Plan:
- Reset, then read 0x00000010 (word addr; idx 4, tag 0) with memory returning line 0xDDDD..._CCCC..._BBBB..._AAAA... after 5 cycles -> mem_read=1, mem_addr=0x0000004; stall for 7 cycles total; proc_rdata=0xAAAAAAAA. An immediate re-read -> stall=0 and no mem_read.
- Write 0x12345678 to 0x00000011 on the filled line -> no stall. Read of 0x00000011 returns 0x12345678. Line is dirty.
- Read 0x00000031 (same idx 4, tag 1) -> mem_write first with mem_addr=0x0000004 and mem_wdata[63:32]=0x12345678. Then mem_read with mem_addr=0x000000C. proc_rdata = word 1 of the new line.
- Write miss to a clean/invalid line -> ALLOCATE only, no write-back. After the fill, the written word is merged, the other 3 words equal the fill data, and dirty=1.
- Assert rst_n=0 in the middle of ALLOCATE -> mem_read drops immediately. After release, a read to the same address misses again.
- Hold proc_read=proc_write=1 on a hit -> behaves as a write. No request for 10 cycles -> mem_read=mem_write=0 and proc_stall=0 throughout.
